// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with 2-entry skid buffer, flush and stall; define PIPE_STALL_CNT_EN to add the stall_cnt counter
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);
  logic [1:0] occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic rdy_q, valid_q;
  logic up_xfer, dn_xfer;
  assign up_xfer = up_valid & rdy_q;
  assign dn_xfer = valid_q & dn_ready;
  always_comb begin
    occ_d = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = 2'd0;
      main_d = BUBBLE_VAL;
      skid_d = BUBBLE_VAL;
    end else if (occ_q == 2'd0) begin
      occ_d = up_xfer ? 2'd1 : 2'd0;
      main_d = up_xfer ? up_data : BUBBLE_VAL;
    end else if (occ_q == 2'd1) begin
      if (up_xfer && dn_xfer) main_d = up_data;
      else if (up_xfer) begin
        occ_d = 2'd2;
        skid_d = up_data;
      end else if (dn_xfer) begin
        occ_d = 2'd0;
        main_d = BUBBLE_VAL;
      end
    end else if (dn_xfer) begin
      occ_d = 2'd1;
      main_d = skid_q;
    end
  end
  // ready and valid are registered from the next occupancy so neither depends combinationally on dn_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= 2'd0;
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
      rdy_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q <= occ_d != 2'd2;
      valid_q <= occ_d != 2'd0;
    end
  end
  assign up_ready = rdy_q;
  assign dn_valid = valid_q;
  assign dn_data = main_q;
  assign occupancy = occ_q;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else if (valid_q && !dn_ready && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: queue-model checked bench for pipe_stage with directed literal vectors
module tb_pipe_stage;
  localparam logic [31:0] BUB = 32'hDEAD_0000;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
  logic up_ready, dn_valid;
  logic [31:0] up_data = 32'd0, dn_data;
  logic [1:0] occupancy;
  int checks = 0, errors = 0, c_seen = 0;
  logic [31:0] mq[$];
  bit up_x, dn_x;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] m_stall = 16'd0;
`endif

  pipe_stage #(.DATA_W(32), .BUBBLE_VAL(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of depth 2 whose head is the output bundle
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
`ifdef PIPE_STALL_CNT_EN
      m_stall = 16'd0;
`endif
    end else begin
      up_x = up_valid && mq.size() < 2;
      dn_x = dn_ready && mq.size() > 0;
`ifdef PIPE_STALL_CNT_EN
      if (mq.size() > 0 && !dn_ready && m_stall != 16'hFFFF) m_stall++;
`endif
      if (dn_x) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (up_x) mq.push_back(up_data);
    end
  end

  always @(negedge clk) begin
    chk("m_dn_valid", {31'd0, dn_valid}, {31'd0, mq.size() > 0});
    chk("m_up_ready", {31'd0, up_ready}, {31'd0, mq.size() < 2});
    chk("m_occupancy", {30'd0, occupancy}, mq.size());
    chk("m_dn_data", dn_data, mq.size() > 0 ? mq[0] : BUB);
`ifdef PIPE_STALL_CNT_EN
    chk("m_stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
`endif
    if (dn_valid && dn_data == 32'hCC) c_seen++;
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    up_valid = v; up_data = d; dn_ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic outs(input string tag, input logic v, input logic rd, input logic [1:0] o, input logic [31:0] d);
    chk({tag, "_dn_valid"}, {31'd0, dn_valid}, {31'd0, v});
    chk({tag, "_up_ready"}, {31'd0, up_ready}, {31'd0, rd});
    chk({tag, "_occ"}, {30'd0, occupancy}, {30'd0, o});
    chk({tag, "_dn_data"}, dn_data, d);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    outs("reset", 1'b0, 1'b1, 2'd0, BUB);
    rst = 1'b1;
    cyc(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, k, 1, 0);
      outs("stream", 1'b1, 1'b1, 2'd1, k);
    end
    cyc(0, 0, 1, 0);
    outs("drain", 1'b0, 1'b1, 2'd0, BUB);
    cyc(1, 32'hA, 1, 0);
    cyc(1, 32'hB, 0, 0);
    outs("stall_full", 1'b1, 1'b0, 2'd2, 32'hA);
    cyc(1, 32'h77, 0, 0);
    outs("stall_hold", 1'b1, 1'b0, 2'd2, 32'hA);
    cyc(0, 0, 1, 0);
    outs("release_b", 1'b1, 1'b1, 2'd1, 32'hB);
    cyc(0, 0, 1, 0);
    outs("release_empty", 1'b0, 1'b1, 2'd0, BUB);
    cyc(1, 32'hA, 1, 0);
    cyc(1, 32'hB, 0, 0);
    outs("pre_flush", 1'b1, 1'b0, 2'd2, 32'hA);
    cyc(1, 32'hCC, 1, 1);
    outs("flush", 1'b0, 1'b1, 2'd0, BUB);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    outs("post_flush", 1'b0, 1'b1, 2'd0, BUB);
    cyc(1, 32'h51, 1, 0);
    cyc(1, 32'h52, 0, 0);
    outs("pre_areset", 1'b1, 1'b0, 2'd2, 32'h51);
    #2 rst = 1'b0;
    #1 outs("areset", 1'b0, 1'b1, 2'd0, BUB);
    cyc(1, 32'h99, 1, 0);
    outs("areset_hold", 1'b0, 1'b1, 2'd0, BUB);
    rst = 1'b1;
    cyc(1, 32'h61, 1, 0);
    outs("first_accept", 1'b1, 1'b1, 2'd1, 32'h61);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), $urandom_range(1000, 9999), 1'($urandom), ($urandom_range(0, 15) == 0));
`ifdef PIPE_STALL_CNT_EN
    cyc(1, 32'h71, 1, 0);
    for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 0);
    chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    cyc(0, 0, 0, 1);
    chk("stall_flush", {16'd0, stall_cnt}, 32'hFFFF);
    outs("stall_flush", 1'b0, 1'b1, 2'd0, BUB);
    #2 rst = 1'b0;
    #1 chk("stall_rst", {16'd0, stall_cnt}, 32'h0);
    rst = 1'b1;
`endif
    cyc(0, 0, 1, 0);
    chk("c_never_out", c_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
